// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row sync, whole-scan debounce, press events.
// Optional auto-repeat of a held single key when KEYPAD_REPEAT_EN is defined.
module keypad_scanner #(
  parameter int SCAN_DIV       = 100_000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 32
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] col,
  input  logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_SCANS);

  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic          r_run;
  logic [1:0]    r_idx;
  logic [DW-1:0] r_dwell;
  logic [15:0]   r_snap;
  logic [15:0]   r_prev;
  logic [15:0]   r_stable;
  logic [CW-1:0] r_cnt;
  logic          r_done;
  logic [3:0]    r_code;
  logic          r_valid;
  logic          r_down;

  logic [3:0]    w_rows;
  logic [15:0]   w_snap_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_accept;
  logic          w_onehot;
  logic          w_press;
  logic          w_fire;
  logic [3:0]    w_idx;

  // Rows are only ever sampled after this two-flop path.
  always_ff @(posedge clk) begin
    r_sync1 <= row;
    r_sync2 <= r_sync1;
  end

  assign w_rows = ~r_sync2;

  always_comb begin
    w_snap_nxt = r_snap;
    for (int r = 0; r < 4; r++) begin
      w_snap_nxt[{2'(r), r_idx}] = w_rows[r];
    end
  end

  always_comb begin
    if (r_snap != r_prev) begin
      w_cnt_nxt = CW'(1);
    end else if (r_cnt == CNT_MAX) begin
      w_cnt_nxt = r_cnt;
    end else begin
      w_cnt_nxt = r_cnt + CW'(1);
    end
  end

  always_comb begin
    w_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (r_snap[i]) w_idx = 4'(i);
    end
  end

  assign w_onehot = (r_snap != 16'd0) &&
                    ((r_snap & (r_snap - 16'd1)) == 16'd0);
  assign w_accept = r_done && (w_cnt_nxt == CNT_MAX) &&
                    (r_snap != r_stable);
  assign w_press  = w_accept && (r_stable == 16'd0) && w_onehot;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_SCANS - 1);

  logic [RW-1:0] r_rep;
  logic          r_armed;
  logic          w_repeat;

  assign w_repeat = r_done && !w_accept && r_armed &&
                    (r_rep == REP_LAST);
  assign w_fire   = w_press | w_repeat;

  // Armed only by a genuine press; any other stable change disarms.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rep   <= '0;
      r_armed <= 1'b0;
    end else if (r_done) begin
      if (w_accept) begin
        r_armed <= w_press;
        r_rep   <= '0;
      end else if (r_armed) begin
        r_rep <= (r_rep == REP_LAST) ? '0 : r_rep + RW'(1);
      end
    end
  end
`else
  assign w_fire = w_press;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_run    <= 1'b0;
      r_idx    <= 2'd0;
      r_dwell  <= '0;
      r_snap   <= 16'd0;
      r_prev   <= 16'd0;
      r_stable <= 16'd0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_code   <= 4'd0;
      r_valid  <= 1'b0;
      r_down   <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_valid <= w_fire;
      if (!r_run) begin
        r_run <= 1'b1;
      end else if (r_dwell == DWELL_LAST) begin
        r_dwell <= '0;
        r_idx   <= r_idx + 2'd1;
        r_snap  <= w_snap_nxt;
        r_done  <= (r_idx == 2'd3);
      end else begin
        r_dwell <= r_dwell + DW'(1);
      end
      // Evaluated in the cycle after the last column sample.
      if (r_done) begin
        r_cnt  <= w_cnt_nxt;
        r_prev <= r_snap;
        if (w_accept) begin
          r_stable <= r_snap;
          r_down   <= |r_snap;
        end
        if (w_press) r_code <= w_idx;
      end
    end
  end

  assign col       = r_run ? ~(4'b0001 << r_idx) : 4'b1111;
  assign key_code  = r_code;
  assign key_valid = r_valid;
  assign key_down  = r_down;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a keypad model and an event scoreboard.
// Define KEYPAD_REPEAT_EN here too when building the repeat variant.
module tb_keypad_scanner;

  localparam int SD  = 8;
  localparam int DB  = 3;
  localparam int RS  = 4;
  localparam int SCN = 4 * SD;
  localparam int LAT = DB * SCN + 1;

  typedef struct {
    int         cyc;
    logic [3:0] code;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic [15:0] keys = 16'd0;

  int   cyc = -1;
  int   checks = 0;
  int   failures = 0;
  int   s;
  logic prev_v = 1'b0;
  logic seen_down;
  exp_t q[$];

  keypad_scanner #(
    .SCAN_DIV(SD),
    .DEBOUNCE_SCANS(DB),
    .REPEAT_SCANS(RS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .col(col),
    .row(row),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_down(key_down)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) cyc <= -1;
    else cyc <= cyc + 1;
  end

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && key_valid) begin
      chk("valid_back_to_back", 32'(prev_v), 32'd0);
      chk("valid_expected", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("valid_code", 32'(key_code), 32'(e.code));
        chk("valid_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    prev_v = key_valid;
  end

  task automatic wait_cyc(input int n);
    for (int i = 0; i < 4000 && cyc < n; i++) @(negedge clk);
    chk("wait_reached", 32'(cyc >= n), 32'd1);
  endtask

  task automatic wait_boundary();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (cyc % SCN == SCN - 1) break;
    end
  endtask

  initial begin
    repeat (5) @(negedge clk);
    chk("rst_col", 32'(col), 32'hF);
    chk("rst_valid", 32'(key_valid), 32'd0);
    chk("rst_down", 32'(key_down), 32'd0);
    chk("rst_code", 32'(key_code), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("col_c0", 32'(col), 32'hE);
    wait_cyc(8);
    chk("col_c1", 32'(col), 32'hD);
    wait_cyc(16);
    chk("col_c2", 32'(col), 32'hB);
    wait_cyc(24);
    chk("col_c3", 32'(col), 32'h7);
    wait_cyc(32);
    chk("col_wrap", 32'(col), 32'hE);

    // Single key 9 held from a scan start.
    wait_boundary();
    keys = 16'd1 << 9;
    s = cyc + 1;
    q.push_back('{s + LAT, 4'd9});
`ifdef KEYPAD_REPEAT_EN
    q.push_back('{s + LAT + RS * SCN, 4'd9});
`endif
    wait_cyc(s + LAT + 1);
    chk("k9_down", 32'(key_down), 32'd1);
    chk("k9_code", 32'(key_code), 32'd9);
    wait_cyc(s + 230);
    wait_boundary();
    chk("k9_events_done", 32'(q.size()), 32'd0);

    // Release: key_down falls after three clean scans.
    keys = 16'd0;
    s = cyc + 1;
    wait_cyc(s + LAT - 1);
    chk("rel_down_held", 32'(key_down), 32'd1);
    wait_cyc(s + LAT);
    chk("rel_down_fall", 32'(key_down), 32'd0);

    // Bouncing key 5 is never accepted.
    wait_boundary();
    seen_down = 1'b0;
    for (int i = 0; i < 10; i++) begin
      keys = (i % 2 == 0) ? (16'd1 << 5) : 16'd0;
      repeat (20) begin
        @(negedge clk);
        seen_down = seen_down | key_down;
      end
    end
    keys = 16'd0;
    repeat (4 * SCN) begin
      @(negedge clk);
      seen_down = seen_down | key_down;
    end
    chk("bounce_down", 32'(seen_down), 32'd0);
    chk("bounce_events", 32'(q.size()), 32'd0);

    // Two keys together, then drop one: no events either way.
    wait_boundary();
    keys = (16'd1 << 0) | (16'd1 << 15);
    s = cyc + 1;
    wait_cyc(s + LAT + 1);
    chk("multi_down", 32'(key_down), 32'd1);
    wait_boundary();
    keys = 16'd1;
    s = cyc + 1;
    wait_cyc(s + LAT + 3);
    chk("drop_down", 32'(key_down), 32'd1);
    chk("drop_code", 32'(key_code), 32'd9);
    wait_boundary();
    keys = 16'd0;
    s = cyc + 1;
    wait_cyc(s + LAT + 3);
    chk("multi_rel_down", 32'(key_down), 32'd0);

    // Reset in the middle of a held key 3.
    wait_boundary();
    keys = 16'd1 << 3;
    s = cyc + 1;
    wait_cyc(s + 50);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_col", 32'(col), 32'hF);
    chk("mid_rst_code", 32'(key_code), 32'd0);
    chk("mid_rst_down", 32'(key_down), 32'd0);
    chk("mid_rst_valid", 32'(key_valid), 32'd0);
    q.push_back('{LAT, 4'd3});
`ifdef KEYPAD_REPEAT_EN
    q.push_back('{LAT + RS * SCN, 4'd3});
`endif
    reset = 1'b0;
    wait_cyc(LAT + 1);
    chk("k3_down", 32'(key_down), 32'd1);
    chk("k3_code", 32'(key_code), 32'd3);
    wait_cyc(LAT + RS * SCN + 20);
    chk("k3_events_done", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
